spi_target: RTL and testbench
=============================

# spi_target

SPI mode-0 responder (target) on the clk domain, the far end of the Port A bit-banged SPI master (PA0=CS, PA1=MOSI, PA2=SCK, PA3=MISO). It exposes a small byte-addressed register bank to the SPI master and a parallel host port to local logic. Command byte selects read or write and a start address; subsequent bytes auto-increment. Used as an on-chip loopback target for SPI driver bring-up and as the template for SPI-attached peripherals.

## Interface
- DEPTH, 16, register bank size in bytes (power of 2, 2..128)
- ADDR_W, $clog2(DEPTH), bank address width (derived; not overridden)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- sck  in  1  SPI clock, asynchronous to clk
- cs_n  in  1  SPI chip select, active-low, asynchronous
- mosi  in  1  SPI data in, asynchronous
- miso  out  1  SPI data out
- miso_oe  out  1  high while frame active (cs_n synced low); drives pad tristate
- host_addr  in  ADDR_W  host read/write address
- host_rdata  out  8  reg[host_addr], combinational
- host_we  in  1  host write strobe
- host_wdata  in  8  host write data
- wr_strobe  out  1  one-cycle pulse per completed SPI write byte
- wr_addr  out  ADDR_W  address of that byte, valid with wr_strobe
- wr_data  out  8  data of that byte, valid with wr_strobe
- frame_done  out  1  one-cycle pulse on synced cs_n rising edge

## Operation
- sck, cs_n, mosi pass through 2-FF synchronisers; a third stage gives edge detect on sck and cs_n.
- States: WAIT_CS, IDLE, CMD, DATA.
- WAIT_CS: entered on reset; leave to IDLE when synced cs_n = 1.
- IDLE: synced cs_n falling → CMD, bit counter = 0.
- CMD: shift mosi in MSB-first on each synced sck rise. After bit 8: bit7 = R (1 read, 0 write), bits[6:0] = start address, bank index = addr mod DEPTH. → DATA. On read, load tx shift reg with reg[addr] and drive its MSB on miso immediately.
- DATA write: each 8 bits received → reg[ptr] <= byte, wr_strobe/wr_addr/wr_data pulse same cycle, ptr <= ptr+1 mod DEPTH.
- DATA read: miso updates on synced sck fall (next bit); after 8th fall, ptr <= ptr+1 mod DEPTH, reload tx shift reg, MSB driven.
- Any state except WAIT_CS: synced cs_n rise → IDLE, frame_done pulse, partial byte discarded; completed bytes kept.
- Simultaneous SPI byte write and host_we to same address: SPI wins, host write lost. Different addresses: both land.
- miso = 0 when miso_oe = 0.
- Reset: all regs 0, state WAIT_CS, miso 0, miso_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, frame_done 0. Reset mid-frame aborts it; no writes from that frame after reset; next frame needs cs_n high first.

## Timing
- Pin-to-detect latency 3 clk. sck high and low each ≥ 4 clk; cs_n setup to first sck rise ≥ 4 clk; at 1.93 MHz clk, max sck ≈ 240 kHz.
- miso valid ≤ 3 clk after pin sck fall; first read bit valid ≤ 4 clk after 8th command sck rise.
- wr_strobe: 3 clk after pin sck rise of bit 8 of the byte.
- host_rdata combinational; host_we takes effect next edge.

## Configuration
- SPI_TARGET_STATUS_EN defined: command address 7'h7F is a read-only status byte = 8-bit frame counter (increments on each frame_done, wraps 255→0, resets to 0); reads past it continue at bank index 0; writes to 7'h7F are discarded with no wr_strobe, then continue at index 0. Undefined: 7'h7F maps to index 7'h7F mod DEPTH like any address; no counter logic.

## Structure
- Shared package: state enum, command-bit positions (R bit 7, addr [6:0]), STATUS_ADDR = 7'h7F.
- One sub-module: spi_target_sync (3-stage synchroniser plus rise/fall detect), instanced for sck and cs_n; mosi uses 2-FF only.

## Test plan
- Write frame 0x03,0xA5,0x5A → reg[3]=0xA5, reg[4]=0x5A; two wr_strobe pulses (3/A5, 4/5A); one frame_done.
- host writes reg[2]=0xC3; read frame 0x82 then 8 clocks → miso byte 0xC3, miso_oe high only during frame.
- Write frame 0x0F,0x11,0x22 (DEPTH 16) → reg[15]=0x11, reg[0]=0x22 (wrap).
- cs_n rises after 4 bits of second data byte in write frame 0x01,0x77,… → reg[1]=0x77, reg[2] unchanged, one wr_strobe.
- reset asserted mid-frame with cs_n low, released, sck continues → no writes until cs_n high then low; all regs 0.
- SPI_TARGET_STATUS_EN: three empty frames then read 0xFF → status byte 0x03, next byte = reg[0].

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI mode-0 target: FSM states and command-byte layout.
package spi_target_pkg;

   typedef enum logic [1:0] {
      WAIT_CS = 2'd0,
      IDLE    = 2'd1,
      CMD     = 2'd2,
      DATA    = 2'd3
   } state_e;

   localparam int         CMD_R_BIT    = 7;
   localparam int         CMD_ADDR_MSB = 6;
   localparam logic [6:0] STATUS_ADDR  = 7'h7F;

endpackage

// File: rtl/spi_target_sync.sv
// Three-stage synchroniser for an asynchronous pin; stage 2 is the level, stages 2/3 give edges.
module spi_target_sync
   import spi_target_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] stages_q;

   always_ff @(posedge clk) begin
      if (reset) stages_q <= '0;
      else       stages_q <= {stages_q[1:0], async_i};
   end

   assign level_o = stages_q[1];
   assign rise_o  = stages_q[1] & ~stages_q[2];
   assign fall_o  = ~stages_q[1] & stages_q[2];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with an auto-incrementing byte register bank and a parallel host port.
// Define SPI_TARGET_STATUS_EN to map command address 7'h7F to a read-only frame counter.
module spi_target
   import spi_target_pkg::*;
#(
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [ADDR_W-1:0] host_addr,
   output logic [7:0]        host_rdata,
   input  logic              host_we,
   input  logic [7:0]        host_wdata,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              frame_done
);

   logic sckLevel, sckRise, sckFall;
   logic csLevel, csRise, csFall;
   logic mosiMeta_q, mosiSync_q;

   spi_target_sync uSckSync (
      .clk(clk), .reset(reset), .async_i(sck),
      .level_o(sckLevel), .rise_o(sckRise), .fall_o(sckFall)
   );

   spi_target_sync uCsSync (
      .clk(clk), .reset(reset), .async_i(cs_n),
      .level_o(csLevel), .rise_o(csRise), .fall_o(csFall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         mosiMeta_q <= 1'b0;
         mosiSync_q <= 1'b0;
      end else begin
         mosiMeta_q <= mosi;
         mosiSync_q <= mosiMeta_q;
      end
   end

   state_e            state_q, state_d;
   logic [2:0]        bitCnt_q, bitCnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        tx_q, tx_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d, ptrAdv;
   logic              rnw_q, rnw_d;
   logic              armed_q, armed_d;
   logic              statusSel_q, statusSel_d;
   logic              wrStrobe_q, wrStrobe_d;
   logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
   logic [7:0]        wrData_q, wrData_d;
   logic              frameDone_q, frameDone_d;
   logic [7:0]        mem_q [DEPTH];
   logic              spiWe;
   logic [ADDR_W-1:0] spiAddr;
   logic [7:0]        spiData;
   logic [7:0]        rxByte;
   logic              statusHit;
   logic [7:0]        statusByte;
   logic              unusedBits;

   assign rxByte     = {shift_q[6:0], mosiSync_q};
   assign unusedBits = ^{sckLevel, rxByte};

   // After the status byte the pointer stays at index 0 instead of advancing.
   assign ptrAdv = statusSel_q ? ptr_q : ptr_q + ADDR_W'(1);

`ifdef SPI_TARGET_STATUS_EN
   logic [7:0] frameCnt_q;

   always_ff @(posedge clk) begin
      if (reset)            frameCnt_q <= 8'h00;
      else if (frameDone_d) frameCnt_q <= frameCnt_q + 8'h01;
   end

   assign statusHit  = (rxByte[CMD_ADDR_MSB:0] == STATUS_ADDR);
   assign statusByte = frameCnt_q;
`else
   assign statusHit  = 1'b0;
   assign statusByte = 8'h00;
`endif

   always_comb begin
      state_d     = state_q;
      bitCnt_d    = bitCnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      ptr_d       = ptr_q;
      rnw_d       = rnw_q;
      armed_d     = armed_q;
      statusSel_d = statusSel_q;
      wrStrobe_d  = 1'b0;
      wrAddr_d    = wrAddr_q;
      wrData_d    = wrData_q;
      frameDone_d = 1'b0;
      spiWe       = 1'b0;
      spiAddr     = ptr_q;
      spiData     = rxByte;
      case (state_q)
         WAIT_CS: if (csLevel) state_d = IDLE;
         IDLE: begin
            if (csFall) begin
               state_d  = CMD;
               bitCnt_d = 3'd0;
            end
         end
         CMD: begin
            if (sckRise) begin
               shift_d  = rxByte;
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  state_d     = DATA;
                  rnw_d       = rxByte[CMD_R_BIT];
                  armed_d     = 1'b0;
                  statusSel_d = statusHit;
                  ptr_d       = statusHit ? '0 : rxByte[ADDR_W-1:0];
                  tx_d        = statusHit ? statusByte : mem_q[rxByte[ADDR_W-1:0]];
               end
            end
         end
         DATA: begin
            // Read falls only count once a data rise has sampled the current bit.
            if (rnw_q) begin
               if (sckRise) begin
                  bitCnt_d = bitCnt_q + 3'd1;
                  armed_d  = 1'b1;
               end else if (sckFall && armed_q) begin
                  armed_d = 1'b0;
                  if (bitCnt_q == 3'd0) begin
                     ptr_d       = ptrAdv;
                     tx_d        = mem_q[ptrAdv];
                     statusSel_d = 1'b0;
                  end else begin
                     tx_d = {tx_q[6:0], 1'b0};
                  end
               end
            end else if (sckRise) begin
               shift_d  = rxByte;
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  ptr_d       = ptrAdv;
                  statusSel_d = 1'b0;
                  if (!statusSel_q) begin
                     spiWe      = 1'b1;
                     wrStrobe_d = 1'b1;
                     wrAddr_d   = ptr_q;
                     wrData_d   = rxByte;
                  end
               end
            end
         end
         default: state_d = WAIT_CS;
      endcase
      // End of frame overrides everything, dropping any byte completing on the same cycle.
      if (state_q != WAIT_CS && csRise) begin
         state_d     = IDLE;
         frameDone_d = 1'b1;
         spiWe       = 1'b0;
         wrStrobe_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT_CS;
         bitCnt_q    <= 3'd0;
         shift_q     <= 8'h00;
         tx_q        <= 8'h00;
         ptr_q       <= '0;
         rnw_q       <= 1'b0;
         armed_q     <= 1'b0;
         statusSel_q <= 1'b0;
         wrStrobe_q  <= 1'b0;
         wrAddr_q    <= '0;
         wrData_q    <= 8'h00;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitCnt_q    <= bitCnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         ptr_q       <= ptr_d;
         rnw_q       <= rnw_d;
         armed_q     <= armed_d;
         statusSel_q <= statusSel_d;
         wrStrobe_q  <= wrStrobe_d;
         wrAddr_q    <= wrAddr_d;
         wrData_q    <= wrData_d;
         frameDone_q <= frameDone_d;
      end
   end

   // An SPI byte write beats a host write to the same address on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         if (host_we && !(spiWe && spiAddr == host_addr)) mem_q[host_addr] <= host_wdata;
         if (spiWe) mem_q[spiAddr] <= spiData;
      end
   end

   assign host_rdata = mem_q[host_addr];
   assign miso_oe    = (state_q == CMD) || (state_q == DATA);
   assign miso       = miso_oe & tx_q[7];
   assign wr_strobe  = wrStrobe_q;
   assign wr_addr    = wrAddr_q;
   assign wr_data    = wrData_q;
   assign frame_done = frameDone_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target (DEPTH 16); status-byte test runs when SPI_TARGET_STATUS_EN is defined.
module tb_spi_target;

   logic       clk = 1'b0;
   logic       reset, sck, cs_n, mosi, host_we;
   logic [3:0] host_addr;
   logic [7:0] host_wdata;
   logic       miso, miso_oe, wr_strobe, frame_done;
   logic [3:0] wr_addr;
   logic [7:0] wr_data, host_rdata;

   int          checkCount = 0;
   int          failCount  = 0;
   int          fdCount    = 0;
   logic [11:0] strobeQ[$];
   logic [7:0]  rx;

   spi_target #(.DEPTH(16)) dut (
      .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe),
      .host_addr(host_addr), .host_rdata(host_rdata),
      .host_we(host_we), .host_wdata(host_wdata),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Record every write pulse and frame-end pulse for later comparison.
   always @(negedge clk) begin
      if (wr_strobe) strobeQ.push_back({wr_addr, wr_data});
      if (frame_done) fdCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkReg(input string tag, input logic [3:0] a, input logic [7:0] expected);
      host_addr = a;
      #1;
      checkOutput(tag, {24'h0, host_rdata}, {24'h0, expected});
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic hostWrite(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_wdata = d;
      @(negedge clk);
      host_we = 1'b0;
   endtask

   task automatic spiBit(input logic b, output logic r);
      mosi = b;
      repeat (8) @(negedge clk);
      r = miso;
      sck = 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic spiXfer(input logic [7:0] txb, output logic [7:0] rxb);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spiBit(txb[i], r);
         rxb[i] = r;
      end
   endtask

   task automatic spiStart();
      @(negedge clk);
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic spiStop();
      repeat (8) @(negedge clk);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // Sends a data byte whose final bit lands on the same edge as a host write.
   task automatic spiWriteCollide(input logic [7:0] b, input logic [3:0] ha, input logic [7:0] hd);
      logic r;
      for (int i = 7; i >= 1; i--) spiBit(b[i], r);
      mosi = b[0];
      repeat (8) @(negedge clk);
      sck = 1'b1;
      @(negedge clk);
      @(negedge clk);
      host_we = 1'b1; host_addr = ha; host_wdata = hd;
      @(negedge clk);
      host_we = 1'b0;
      repeat (5) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic applyStimulus();
      logic r;
      int   fd0;

      // Reset state
      reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
      host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      checkOutput("rstMiso", {31'h0, miso}, 32'h0);
      checkOutput("rstMisoOe", {31'h0, miso_oe}, 32'h0);
      checkOutput("rstStrobe", {31'h0, wr_strobe}, 32'h0);
      checkOutput("rstWrAddr", {28'h0, wr_addr}, 32'h0);
      checkOutput("rstWrData", {24'h0, wr_data}, 32'h0);
      checkOutput("rstFrameDone", {31'h0, frame_done}, 32'h0);
      checkReg("rstReg0", 4'h0, 8'h00);
      repeat (8) @(negedge clk);

      // Write frame 03 A5 5A
      strobeQ.delete(); fd0 = fdCount;
      spiStart(); spiXfer(8'h03, rx); spiXfer(8'hA5, rx); spiXfer(8'h5A, rx); spiStop();
      checkReg("wrReg3", 4'h3, 8'hA5);
      checkReg("wrReg4", 4'h4, 8'h5A);
      checkOutput("wrStrobeCnt", strobeQ.size(), 2);
      checkOutput("wrStrobe0", {20'h0, strobeQ[0]}, {20'h0, 4'h3, 8'hA5});
      checkOutput("wrStrobe1", {20'h0, strobeQ[1]}, {20'h0, 4'h4, 8'h5A});
      checkOutput("wrFrameDone", fdCount - fd0, 1);

      // Host write then SPI read of reg[2]
      hostWrite(4'h2, 8'hC3);
      checkReg("hostReg2", 4'h2, 8'hC3);
      spiStart(); spiXfer(8'h82, rx);
      checkOutput("rdOeInFrame", {31'h0, miso_oe}, 32'h1);
      spiXfer(8'h00, rx);
      checkOutput("rdByte", {24'h0, rx}, {24'h0, 8'hC3});
      spiXfer(8'h00, rx);
      checkOutput("rdNextByte", {24'h0, rx}, {24'h0, 8'hA5});
      spiStop();
      checkOutput("rdOeAfter", {31'h0, miso_oe}, 32'h0);
      checkOutput("rdMisoAfter", {31'h0, miso}, 32'h0);

      // Address wrap at DEPTH
      spiStart(); spiXfer(8'h0F, rx); spiXfer(8'h11, rx); spiXfer(8'h22, rx); spiStop();
      checkReg("wrapReg15", 4'hF, 8'h11);
      checkReg("wrapReg0", 4'h0, 8'h22);

      // Partial byte discarded on cs_n rise
      strobeQ.delete();
      spiStart(); spiXfer(8'h01, rx); spiXfer(8'h77, rx);
      for (int i = 0; i < 4; i++) spiBit(1'b1, r);
      spiStop();
      checkReg("partReg1", 4'h1, 8'h77);
      checkReg("partReg2", 4'h2, 8'hC3);
      checkOutput("partStrobeCnt", strobeQ.size(), 1);

      // Collision with host write: same address then different address
      spiStart(); spiXfer(8'h08, rx); spiWriteCollide(8'h3C, 4'h8, 8'hEE); spiStop();
      checkReg("collSameAddr", 4'h8, 8'h3C);
      spiStart(); spiXfer(8'h09, rx); spiWriteCollide(8'h4D, 4'hA, 8'h6B); spiStop();
      checkReg("collSpiAddr", 4'h9, 8'h4D);
      checkReg("collHostAddr", 4'hA, 8'h6B);

      // Reset mid-frame with cs_n held low
      spiStart(); spiXfer(8'h05, rx);
      for (int i = 0; i < 4; i++) spiBit(1'b0, r);
      applyReset();
      strobeQ.delete();
      spiXfer(8'h99, rx); spiXfer(8'h98, rx); spiXfer(8'h97, rx);
      checkOutput("rstFrameStrobes", strobeQ.size(), 0);
      checkOutput("rstFrameOe", {31'h0, miso_oe}, 32'h0);
      for (int a = 0; a < 16; a++) checkReg($sformatf("rstClear%0d", a), 4'(a), 8'h00);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
      spiStart(); spiXfer(8'h06, rx); spiXfer(8'h44, rx); spiStop();
      checkReg("recoverReg6", 4'h6, 8'h44);
      checkOutput("recoverStrobes", strobeQ.size(), 1);

`ifdef SPI_TARGET_STATUS_EN
      applyReset();
      repeat (12) @(negedge clk);
      hostWrite(4'h0, 8'h5B);
      for (int i = 0; i < 3; i++) begin
         spiStart(); spiStop();
      end
      spiStart(); spiXfer(8'hFF, rx);
      spiXfer(8'h00, rx);
      checkOutput("statusByte", {24'h0, rx}, {24'h0, 8'h03});
      spiXfer(8'h00, rx);
      checkOutput("statusNext", {24'h0, rx}, {24'h0, 8'h5B});
      spiStop();
`endif
   endtask

   initial begin
      applyStimulus();
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
